// File: rtl/serial_parity_checker_if.sv
// Serial parity link receive-side bundle: bit strobe in, frame valid/ready out.
// err_count exists only when PARITY_ERR_CNT_EN is defined.
interface serial_parity_checker_if #(
  parameter int DATA_W = 4
);
  logic              rx_bit;
  logic              rx_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0]        err_count;
`endif

  modport master (
    output rx_bit, rx_valid, out_ready,
    input  data_out, data_valid, parity_err, frame_err, overrun, busy
`ifdef PARITY_ERR_CNT_EN
    , err_count
`endif
  );

  modport slave (
    input  rx_bit, rx_valid, out_ready,
    output data_out, data_valid, parity_err, frame_err, overrun, busy
`ifdef PARITY_ERR_CNT_EN
    , err_count
`endif
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Deserialises start/data(LSB first)/even-parity/stop frames onto a valid/ready port.
// Optional saturating parity-error counter enabled by defining PARITY_ERR_CNT_EN.
module serial_parity_checker #(
  parameter int DATA_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_parity_checker_if.slave  link
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sr, w_sr_nxt;
  logic              r_par;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid, r_parity_err, r_frame_err, r_overrun, r_busy;
  logic              w_start, w_shift, w_last, w_par_ld, w_commit, w_consume, w_busy_d;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    w_state_nxt = r_state;
    if (link.rx_valid) begin
      case (r_state)
        S_IDLE:   if (!link.rx_bit) w_state_nxt = S_DATA;
        S_DATA:   if (w_last) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // busy covers the cycle after the stop strobe, so it looks at both current and next state
  always_comb begin
    w_start   = link.rx_valid && (r_state == S_IDLE) && !link.rx_bit;
    w_shift   = link.rx_valid && (r_state == S_DATA);
    w_par_ld  = link.rx_valid && (r_state == S_PARITY);
    w_commit  = link.rx_valid && (r_state == S_STOP);
    w_consume = r_data_valid && link.out_ready;
    w_busy_d  = (r_state != S_IDLE) || (w_state_nxt != S_IDLE);
  end

  generate
    if (DATA_W == 1) begin : g_sr1
      assign w_sr_nxt = link.rx_bit;
    end else begin : g_srn
      assign w_sr_nxt = {link.rx_bit, r_sr[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sr  <= '0;
      r_par <= 1'b0;
    end else begin
      if (w_start) r_cnt <= '0;
      if (w_shift) begin
        r_sr  <= w_sr_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_par_ld) r_par <= link.rx_bit;
    end
  end

  // A commit wins over a consume; overrun reflects whether the held frame was lost
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= w_busy_d;
      if (w_commit) begin
        r_data_out   <= r_sr;
        r_data_valid <= 1'b1;
        r_parity_err <= (^r_sr) ^ r_par;
        r_frame_err  <= ~link.rx_bit;
        r_overrun    <= r_data_valid & ~link.out_ready;
      end else if (w_consume) begin
        r_data_valid <= 1'b0;
        r_parity_err <= 1'b0;
        r_frame_err  <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] r_err_count;
  always_ff @(posedge clk) begin
    if (!reset)
      r_err_count <= '0;
    else if (w_commit && ((^r_sr) ^ r_par) && (r_err_count != 8'hFF))
      r_err_count <= r_err_count + 8'd1;
  end
  assign link.err_count = r_err_count;
`endif

  assign link.data_out   = r_data_out;
  assign link.data_valid = r_data_valid;
  assign link.parity_err = r_parity_err;
  assign link.frame_err  = r_frame_err;
  assign link.overrun    = r_overrun;
  assign link.busy       = r_busy;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench for serial_parity_checker (DATA_W=4): directed frames, monitor pops on handshake.
module tb_serial_parity_checker;
  localparam int DATA_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_parity_checker_if #(.DATA_W(DATA_W)) link();
  serial_parity_checker #(.DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .link(link));

  typedef struct packed {
    logic [3:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;
  logic [3:0] sw_d;
  logic       sw_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [3:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.ov = ov;
    q.push_back(e);
    if (pe && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic gapw(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic b);
    link.rx_bit   = b;
    link.rx_valid = 1'b1;
    @(posedge clk); #1;
    link.rx_valid = 1'b0;
    link.rx_bit   = 1'b1;
  endtask

  // returns one cycle after the stop strobe, i.e. when the frame should be visible
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input int gap);
    strobe(1'b0); gapw(gap);
    for (int i = 0; i < 4; i++) begin strobe(d[i]); gapw(gap); end
    strobe(p); gapw(gap);
    strobe(s);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && link.data_valid === 1'b1 && link.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("sb_unexpected_frame", {28'd0, link.data_out}, 32'hFFFF_FFFF);
      end else begin
        mon_e = q.pop_front();
        check("sb_data_out",   link.data_out,   mon_e.d);
        check("sb_parity_err", link.parity_err, mon_e.pe);
        check("sb_frame_err",  link.frame_err,  mon_e.fe);
        check("sb_overrun",    link.overrun,    mon_e.ov);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"},   link.data_out,   0);
    check({tag, "_data_valid"}, link.data_valid, 0);
    check({tag, "_parity_err"}, link.parity_err, 0);
    check({tag, "_frame_err"},  link.frame_err,  0);
    check({tag, "_overrun"},    link.overrun,    0);
    check({tag, "_busy"},       link.busy,       0);
`ifdef PARITY_ERR_CNT_EN
    check({tag, "_err_count"},  link.err_count,  0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    link.rx_bit = 1'b1; link.rx_valid = 1'b0; link.out_ready = 1'b1;
    gapw(3);
    check_all_zero("reset");
    reset = 1'b1;
    gapw(1);

    // 1: good frame 4'hB, check latency and busy window
    push(4'hB, 1'b0, 1'b0, 1'b0);
    strobe(1'b0);
    check("t1_busy_start", link.busy, 1);
    strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    check("t1_no_early_valid", link.data_valid, 0);
    strobe(1'b1);
    check("t1_latency_valid", link.data_valid, 1);
    check("t1_busy_after_stop", link.busy, 1);
    gapw(1);
    check("t1_consumed", link.data_valid, 0);
    check("t1_busy_idle", link.busy, 0);

    // 2: parity error
    push(4'hB, 1'b1, 1'b0, 1'b0);
    send_frame(4'hB, 1'b0, 1'b1, 0);
    gapw(1);
    check("t2_perr_cleared", link.parity_err, 0);
    check("t2_data_hold", link.data_out, 4'hB);
`ifdef PARITY_ERR_CNT_EN
    check("t2_err_count", link.err_count, 1);
`endif

    // 3: framing error, data still delivered
    push(4'h0, 1'b0, 1'b1, 1'b0);
    send_frame(4'h0, 1'b0, 1'b0, 0);
    gapw(1);
    check("t3_ferr_cleared", link.frame_err, 0);

    // 4: overrun with out_ready low
    link.out_ready = 1'b0;
    send_frame(4'h3, 1'b0, 1'b1, 0);
    check("t4_first_valid", link.data_valid, 1);
    check("t4_first_ovr", link.overrun, 0);
    gapw(3);
    check("t4_held_data", link.data_out, 4'h3);
    push(4'h5, 1'b0, 1'b0, 1'b1);
    send_frame(4'h5, 1'b0, 1'b1, 0);
    check("t4_overwrite_data", link.data_out, 4'h5);
    check("t4_overrun", link.overrun, 1);
    gapw(2);
    check("t4_still_valid", link.data_valid, 1);
    link.out_ready = 1'b1;
    gapw(1);
    check("t4_valid_drop", link.data_valid, 0);
    check("t4_ovr_clear", link.overrun, 0);
    check("t4_data_hold", link.data_out, 4'h5);

    // 5: gapped strobes with idle-line bits first
    repeat (3) begin
      strobe(1'b1);
      check("t5_idle_busy", link.busy, 0);
      gapw(2);
    end
    push(4'hB, 1'b0, 1'b0, 1'b0);
    send_frame(4'hB, 1'b1, 1'b1, 2);
    check("t5_valid", link.data_valid, 1);
    gapw(1);

    // 6: reset drops a held frame and a partial frame
    link.out_ready = 1'b0;
    send_frame(4'h3, 1'b0, 1'b1, 0);
    strobe(1'b0); strobe(1'b1); strobe(1'b1);
    reset = 1'b0;
    gapw(1);
    reset = 1'b1;
    exp_cnt = 0;
    check_all_zero("t6_reset");
    link.out_ready = 1'b1;
    push(4'hB, 1'b0, 1'b0, 1'b0);
    send_frame(4'hB, 1'b1, 1'b1, 0);
    check("t6_valid", link.data_valid, 1);
    gapw(1);

    // sweep: every data value with both parity bits, back-to-back frames
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 2; p++) begin
        sw_d = 4'(d);
        sw_p = p[0];
        push(sw_d, sw_p ^ (^sw_d), 1'b0, 1'b0);
        send_frame(sw_d, sw_p, 1'b1, 0);
      end
    end
    gapw(3);
`ifdef PARITY_ERR_CNT_EN
    check("final_err_count", link.err_count, exp_cnt);
`endif
    check("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
